wave_regfile: RTL and testbench

- Per-lane vector register file holding register contexts for NUM_WAVES resident waves. Successor to the single-context lane register file.
- Adds parametrised depth and width, multi-wave contexts, a 1-cycle read handshake, a pending-write scoreboard, and a sequential context-clear engine.
- Sits between the SIMD issue stage (reads, scoreboard set) and the ALU/LSU writeback (writes). One instance per SIMD lane.

---
 rtl/wave_regfile.sv | 160 ++++++++++++++++
 tb/tb_wave_regfile.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_regfile.sv
// Per-lane register file holding NUM_WAVES wave contexts, with a pending-write scoreboard
// and a sequential context-clear engine. Define WAVE_REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module wave_regfile #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int NUM_WAVES  = 4,
  parameter int WAVE_SIZE  = 32,
  parameter int LANE_WIDTH = 16,
  localparam int RA_W = $clog2(NUM_REGS),
  localparam int WV_W = $clog2(NUM_WAVES),
  localparam int WC_W = $clog2(WAVE_SIZE/LANE_WIDTH)+1,
  localparam int LN_W = $clog2(LANE_WIDTH)+1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           block_id,
  input  logic [31:0]           block_dim,
  input  logic [31:0]           wave_base,
  input  logic [WC_W-1:0]       wave_cycle,
  input  logic [LN_W-1:0]       lane_id,
  input  logic                  rd_req,
  output logic                  rd_ready,
  input  logic [WV_W-1:0]       rd_wave,
  input  logic [RA_W-1:0]       rm,
  input  logic [RA_W-1:0]       rn,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rm_data,
  output logic [DATA_WIDTH-1:0] rn_data,
  output logic                  rd_hazard,
  input  logic                  wr_en,
  input  logic [WV_W-1:0]       wr_wave,
  input  logic [RA_W-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  input  logic                  sb_set,
  input  logic [WV_W-1:0]       sb_wave,
  input  logic [RA_W-1:0]       sb_addr,
  input  logic                  clr_req,
  input  logic [WV_W-1:0]       clr_wave,
  output logic                  clr_busy
);
  localparam int NUM_GP = NUM_REGS-4;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                             state_q, state_d;
  logic [RA_W-1:0]                    cnt_q, cnt_d;
  logic [WV_W-1:0]                    cwave_q, cwave_d;
  logic [DATA_WIDTH-1:0]              mem_q [NUM_WAVES][NUM_GP];
  logic [NUM_WAVES-1:0][NUM_GP-1:0]   sb_q, sb_d;

  logic                  clr_zero, wr_ok, rd_acc;
  logic [63:0]           tid;
  logic [RA_W-1:0]       ra   [2];
  logic [DATA_WIDTH-1:0] rval [2];
  logic                  pend [2];

  assign clr_busy = (state_q == CLEAR);
  assign clr_zero = clr_busy;
  assign rd_ready = !clr_busy;
  assign rd_acc   = rd_req & rd_ready;
  // Writes into the context being wiped are dropped so the clear engine owns it exclusively.
  assign wr_ok    = wr_en && (wr_addr < RA_W'(NUM_GP)) && !(clr_busy && (wr_wave == cwave_q));

  always_comb begin
    ra[0] = rm;
    ra[1] = rn;
    tid   = 64'(wave_base) * 64'(WAVE_SIZE) + 64'(wave_cycle) * 64'(LANE_WIDTH) + 64'(lane_id);
    for (int p = 0; p < 2; p++) begin
      rval[p] = '0;
      pend[p] = 1'b0;
      if (ra[p] < RA_W'(NUM_GP)) begin
        rval[p] = mem_q[rd_wave][ra[p]];
        pend[p] = sb_q[rd_wave][ra[p]];
`ifdef WAVE_REGFILE_BYPASS_EN
        if (wr_ok && (wr_wave == rd_wave) && (wr_addr == ra[p])) begin
          rval[p] = wr_data;
          pend[p] = 1'b0;
        end
`endif
      end else if (ra[p] == RA_W'(NUM_REGS-4)) begin
        rval[p] = DATA_WIDTH'(block_id);
      end else if (ra[p] == RA_W'(NUM_REGS-3)) begin
        rval[p] = DATA_WIDTH'(block_dim);
      end else if (ra[p] == RA_W'(NUM_REGS-2)) begin
        rval[p] = DATA_WIDTH'(tid);
      end
    end
  end

  // Scoreboard priority: clear-engine zero, then write clear, then set (set wins).
  always_comb begin
    sb_d = sb_q;
    if (clr_zero) sb_d[cwave_q][cnt_q] = 1'b0;
    if (wr_ok)    sb_d[wr_wave][wr_addr] = 1'b0;
    if (sb_set && (sb_addr < RA_W'(NUM_GP))) sb_d[sb_wave][sb_addr] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cwave_d = cwave_q;
    case (state_q)
      IDLE: if (clr_req) begin
        state_d = CLEAR;
        cnt_d   = '0;
        cwave_d = clr_wave;
      end
      CLEAR: begin
        if (cnt_q == RA_W'(NUM_GP-1)) state_d = IDLE;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cwave_q <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cwave_q <= cwave_d;
      sb_q    <= sb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WAVES; w++)
        for (int r = 0; r < NUM_GP; r++)
          mem_q[w][r] <= '0;
    end else begin
      if (clr_zero) mem_q[cwave_q][cnt_q] <= '0;
      if (wr_ok)    mem_q[wr_wave][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_hazard <= 1'b0;
      rm_data   <= '0;
      rn_data   <= '0;
      wr_err    <= 1'b0;
    end else begin
      rd_valid  <= rd_acc;
      rd_hazard <= rd_acc & (pend[0] | pend[1]);
      wr_err    <= wr_en & ~wr_ok;
      if (rd_acc) begin
        rm_data <= rval[0];
        rn_data <= rval[1];
      end
    end
  end

endmodule

// File: tb/tb_wave_regfile.sv
// Self-checking bench for wave_regfile: directed scenarios plus random traffic against an array model.
module tb_wave_regfile;
  localparam int NR = 32, NW = 4, NGP = NR-4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] block_id, block_dim, wave_base;
  logic [1:0]  wave_cycle;
  logic [4:0]  lane_id;
  logic        rd_req, rd_ready, rd_valid, rd_hazard;
  logic [1:0]  rd_wave, wr_wave, sb_wave, clr_wave;
  logic [4:0]  rm, rn, wr_addr, sb_addr;
  logic [63:0] rm_data, rn_data, wr_data;
  logic        wr_en, wr_err, sb_set, clr_req, clr_busy;

  int tot = 0, bad = 0;

  logic [63:0] mem [NW][NGP];
  bit          sb  [NW][NGP];
  int          clr_left, clr_w;
  bit          w_ok;
  logic [63:0] e_rm, e_rn;
  bit          e_valid, e_hz, e_err, e_busy;

  wave_regfile dut (
    .clk(clk), .rst_n(rst_n), .block_id(block_id), .block_dim(block_dim),
    .wave_base(wave_base), .wave_cycle(wave_cycle), .lane_id(lane_id),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_wave(rd_wave), .rm(rm), .rn(rn),
    .rd_valid(rd_valid), .rm_data(rm_data), .rn_data(rn_data), .rd_hazard(rd_hazard),
    .wr_en(wr_en), .wr_wave(wr_wave), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .sb_set(sb_set), .sb_wave(sb_wave), .sb_addr(sb_addr),
    .clr_req(clr_req), .clr_wave(clr_wave), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  function automatic bit fwd_hit(int w, int a);
    return w_ok && (int'(wr_wave) == w) && (int'(wr_addr) == a);
  endfunction

  function automatic logic [63:0] ref_read(int w, int a);
`ifdef WAVE_REGFILE_BYPASS_EN
    if (fwd_hit(w, a)) return wr_data;
`endif
    if (a < NGP)   return mem[w][a];
    if (a == NR-4) return 64'(block_id);
    if (a == NR-3) return 64'(block_dim);
    if (a == NR-2) return 64'(wave_base) * 32 + 64'(wave_cycle) * 16 + 64'(lane_id);
    return 64'd0;
  endfunction

  function automatic bit ref_pend(int w, int a);
    if (a >= NGP) return 1'b0;
`ifdef WAVE_REGFILE_BYPASS_EN
    if (fwd_hit(w, a)) return 1'b0;
`endif
    return sb[w][a];
  endfunction

  function automatic void model_reset();
    for (int w = 0; w < NW; w++)
      for (int r = 0; r < NGP; r++) begin
        mem[w][r] = 64'd0;
        sb[w][r]  = 1'b0;
      end
    clr_left = 0; clr_w = 0;
    e_rm = 64'd0; e_rn = 64'd0;
    e_valid = 0; e_hz = 0; e_err = 0; e_busy = 0;
  endfunction

  task automatic idle();
    rd_req = 0; wr_en = 0; sb_set = 0; clr_req = 0;
  endtask

  // Predict the outcome of the coming edge from the driven inputs, advance the model, then clock.
  task automatic step();
    bit busy, acc;
    busy = (clr_left != 0);
    acc  = rd_req && !busy;
    w_ok = wr_en && (wr_addr < NGP) && !(busy && int'(wr_wave) == clr_w);
    if (acc) begin
      e_rm = ref_read(rd_wave, rm);
      e_rn = ref_read(rd_wave, rn);
    end
    e_hz    = acc && (ref_pend(rd_wave, rm) || ref_pend(rd_wave, rn));
    e_valid = acc;
    e_err   = wr_en && !w_ok;
    if (busy) begin
      mem[clr_w][NGP-clr_left] = 64'd0;
      sb[clr_w][NGP-clr_left]  = 1'b0;
      clr_left--;
    end else if (clr_req) begin
      clr_left = NGP;
      clr_w    = clr_wave;
    end
    if (w_ok) begin
      mem[wr_wave][wr_addr] = wr_data;
      sb[wr_wave][wr_addr]  = 1'b0;
    end
    if (sb_set && sb_addr < NGP) sb[sb_wave][sb_addr] = 1'b1;
    e_busy = (clr_left != 0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    block_id = 0; block_dim = 0; wave_base = 0; wave_cycle = 0; lane_id = 0;
    rd_wave = 0; rm = 0; rn = 0; wr_wave = 0; wr_addr = 0; wr_data = 0;
    sb_wave = 0; sb_addr = 0; clr_wave = 0;
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    tot++; if ({rd_valid, rd_hazard, wr_err, clr_busy} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {rd_valid, rd_hazard, wr_err, clr_busy}); end
    tot++; if (rm_data !== 64'd0 || rn_data !== 64'd0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", rm_data, rn_data); end
    tot++; if (rd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", rd_ready); end
    rst_n = 1;
    rd_req = 1; rd_wave = 0; rm = 3; rn = 31;
    step();
    tot++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", rd_valid); end
    tot++; if (rm_data !== 64'd0 || rn_data !== 64'd0) begin bad++; $display("FAIL first_data got=%h/%h exp=0", rm_data, rn_data); end
    idle();
    step();
    tot++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL valid_drop got=%b exp=0", rd_valid); end
  endtask

  task automatic test_special();
    idle();
    block_id = 5; block_dim = 64; wave_base = 2; wave_cycle = 1; lane_id = 7;
    rd_req = 1; rd_wave = 1; rm = 28; rn = 30;
    step();
    tot++; if (rm_data !== 64'd5 || rn_data !== 64'd87) begin bad++; $display("FAIL special_tid got=%0d/%0d exp=5/87", rm_data, rn_data); end
    rm = 29; rn = 31;
    step();
    tot++; if (rm_data !== 64'd64 || rn_data !== 64'd0) begin bad++; $display("FAIL special_dim got=%0d/%0d exp=64/0", rm_data, rn_data); end
    for (int i = 0; i < 8; i++) begin
      block_id = $urandom; block_dim = $urandom; wave_base = $urandom;
      wave_cycle = 2'($urandom); lane_id = 5'($urandom);
      rm = 5'($urandom_range(28, 31)); rn = 5'($urandom_range(28, 31));
      step();
      tot++; if (rm_data !== e_rm || rn_data !== e_rn) begin bad++; $display("FAIL special_rand got=%h/%h exp=%h/%h", rm_data, rn_data, e_rm, e_rn); end
    end
    rd_req = 0;
    step();
    tot++; if (rm_data !== e_rm || rn_data !== e_rn) begin bad++; $display("FAIL data_hold got=%h/%h exp=%h/%h", rm_data, rn_data, e_rm, e_rn); end
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1; wr_wave = 1; wr_addr = 4; wr_data = 64'hDEAD;
    step();
    idle();
    rd_req = 1; rd_wave = 1; rm = 4; rn = 4;
    step();
    tot++; if (rm_data !== 64'hDEAD || rn_data !== 64'hDEAD) begin bad++; $display("FAIL wr_rd_w1 got=%h/%h exp=dead", rm_data, rn_data); end
    rd_wave = 0;
    step();
    tot++; if (rm_data !== 64'd0) begin bad++; $display("FAIL wr_rd_w0 got=%h exp=0", rm_data); end
  endtask

  task automatic test_wr_err();
    idle();
    block_dim = 64;
    wr_en = 1; wr_wave = 0; wr_addr = 29; wr_data = 64'h1234;
    step();
    tot++; if (wr_err !== 1'b1) begin bad++; $display("FAIL wr_err_set got=%b exp=1", wr_err); end
    wr_en = 0;
    rd_req = 1; rd_wave = 0; rm = 29; rn = 27;
    step();
    tot++; if (wr_err !== 1'b0) begin bad++; $display("FAIL wr_err_pulse got=%b exp=0", wr_err); end
    tot++; if (rm_data !== 64'd64) begin bad++; $display("FAIL r29_dim got=%0d exp=64", rm_data); end
  endtask

  task automatic test_scoreboard();
    idle();
    sb_set = 1; sb_wave = 2; sb_addr = 10;
    step();
    sb_set = 0;
    rd_req = 1; rd_wave = 2; rm = 10; rn = 31;
    step();
    tot++; if (rd_hazard !== 1'b1) begin bad++; $display("FAIL sb_pending got=%b exp=1", rd_hazard); end
    rd_req = 0; wr_en = 1; wr_wave = 2; wr_addr = 10; wr_data = 64'h55;
    step();
    wr_en = 0; rd_req = 1;
    step();
    tot++; if (rd_hazard !== 1'b0) begin bad++; $display("FAIL sb_cleared got=%b exp=0", rd_hazard); end
    rd_req = 0; wr_en = 1; sb_set = 1; sb_wave = 2; sb_addr = 10;
    step();
    wr_en = 0; sb_set = 0; rd_req = 1; rm = 31; rn = 10;
    step();
    tot++; if (rd_hazard !== 1'b1) begin bad++; $display("FAIL sb_set_wins got=%b exp=1", rd_hazard); end
    rd_req = 0; sb_set = 1; sb_addr = 29;
    step();
    sb_set = 0; rd_req = 1; rm = 29; rn = 29;
    step();
    tot++; if (rd_hazard !== 1'b0) begin bad++; $display("FAIL sb_special got=%b exp=0", rd_hazard); end
  endtask

  task automatic test_same_cycle();
    logic [63:0] a, b;
    a = 64'hA5A5_0001; b = 64'h5A5A_0002;
    idle();
    wr_en = 1; wr_wave = 1; wr_addr = 6; wr_data = a;
    step();
    wr_en = 0; sb_set = 1; sb_wave = 1; sb_addr = 6;
    step();
    sb_set = 0; wr_en = 1; wr_data = b; rd_req = 1; rd_wave = 1; rm = 6; rn = 31;
    step();
`ifdef WAVE_REGFILE_BYPASS_EN
    tot++; if (rm_data !== b || rd_hazard !== 1'b0) begin bad++; $display("FAIL same_cycle got=%h hz=%b exp=%h hz=0", rm_data, rd_hazard, b); end
`else
    tot++; if (rm_data !== a || rd_hazard !== 1'b1) begin bad++; $display("FAIL same_cycle got=%h hz=%b exp=%h hz=1", rm_data, rd_hazard, a); end
`endif
    idle(); rd_req = 1;
    step();
    tot++; if (rm_data !== b || rd_hazard !== 1'b0) begin bad++; $display("FAIL after_same got=%h hz=%b exp=%h hz=0", rm_data, rd_hazard, b); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rd_req  = ($urandom_range(0, 3) != 0);
      rd_wave = 2'($urandom); rm = 5'($urandom); rn = 5'($urandom);
      wr_en   = $urandom_range(0, 1);
      wr_wave = 2'($urandom);
      wr_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(28, 31)) : 5'($urandom_range(0, 27));
      wr_data = {$urandom, $urandom};
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_wave = 2'($urandom); sb_addr = 5'($urandom);
      block_id = $urandom; block_dim = $urandom; wave_base = $urandom;
      wave_cycle = 2'($urandom); lane_id = 5'($urandom);
      step();
      tot++; if (rd_valid !== e_valid || rd_hazard !== e_hz) begin bad++; $display("FAIL rand_ctl i=%0d got=%b%b exp=%b%b", i, rd_valid, rd_hazard, e_valid, e_hz); end
      tot++; if (rm_data !== e_rm || rn_data !== e_rn) begin bad++; $display("FAIL rand_data i=%0d got=%h/%h exp=%h/%h", i, rm_data, rn_data, e_rm, e_rn); end
      tot++; if (wr_err !== e_err || clr_busy !== e_busy) begin bad++; $display("FAIL rand_err i=%0d got=%b%b exp=%b%b", i, wr_err, clr_busy, e_err, e_busy); end
    end
    idle();
  endtask

  task automatic test_clear();
    int n;
    idle();
    for (int r = 0; r < NGP; r++) begin
      wr_en = 1; wr_wave = 3; wr_addr = 5'(r); wr_data = {$urandom, $urandom};
      sb_set = 1; sb_wave = 3; sb_addr = 5'((r + 1) % NGP);
      step();
      wr_wave = 0; wr_data = {$urandom, $urandom}; sb_set = 0;
      step();
    end
    idle();
    clr_req = 1; clr_wave = 3;
    step();
    clr_req = 0;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      tot++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL clr_ready n=%0d got=%b exp=0", n, rd_ready); end
      rd_req = 1; rd_wave = 0; rm = 0; rn = 1;
      wr_en = (n == 5 || n == 6);
      wr_wave = (n == 5) ? 2'd3 : 2'd0; wr_addr = 5'd2; wr_data = {$urandom, $urandom};
      step();
      n++;
      tot++; if (rd_valid !== 1'b0 || clr_busy !== e_busy) begin bad++; $display("FAIL clr_cycle n=%0d got=%b%b exp=0%b", n, rd_valid, clr_busy, e_busy); end
      if (n == 6) begin tot++; if (wr_err !== 1'b1) begin bad++; $display("FAIL clr_wr_err got=%b exp=1", wr_err); end end
      if (n == 7) begin tot++; if (wr_err !== 1'b0) begin bad++; $display("FAIL clr_wr_other got=%b exp=0", wr_err); end end
    end
    tot++; if (n != NGP) begin bad++; $display("FAIL clr_len got=%0d exp=%0d", n, NGP); end
    idle();
    rd_req = 1;
    for (int w = 0; w < 4; w += 3) begin
      rd_wave = 2'(w);
      for (int r = 0; r < NGP; r++) begin
        rm = 5'(r); rn = 5'(NGP-1-r);
        step();
        tot++; if (rm_data !== e_rm || rn_data !== e_rn || rd_hazard !== e_hz) begin bad++; $display("FAIL clr_read w=%0d r=%0d got=%h/%h/%b exp=%h/%h/%b", w, r, rm_data, rn_data, rd_hazard, e_rm, e_rn, e_hz); end
        if (w == 3) begin tot++; if (rm_data !== 64'd0) begin bad++; $display("FAIL clr_zero r=%0d got=%h exp=0", r, rm_data); end end
      end
    end
    idle();
  endtask

  task automatic test_reset_midclear();
    idle();
    clr_req = 1; clr_wave = 1;
    step();
    clr_req = 0;
    step(); step();
    tot++; if (clr_busy !== 1'b1) begin bad++; $display("FAIL midclr_busy got=%b exp=1", clr_busy); end
    rst_n = 0;
    #1;
    tot++; if (clr_busy !== 1'b0 || rd_valid !== 1'b0 || rd_ready !== 1'b1) begin bad++; $display("FAIL async_reset got=%b%b%b exp=001", clr_busy, rd_valid, rd_ready); end
    model_reset();
    #2 rst_n = 1;
    rd_req = 1; rd_wave = 0; rm = 5; rn = 6;
    step();
    tot++; if (clr_busy !== 1'b0 || rd_valid !== 1'b1 || rm_data !== 64'd0) begin bad++; $display("FAIL post_reset got=%b%b %h exp=01 0", clr_busy, rd_valid, rm_data); end
    idle();
  endtask

  initial begin
    test_reset();
    test_special();
    test_write_read();
    test_wr_err();
    test_scoreboard();
    test_same_cycle();
    test_random();
    test_clear();
    test_reset_midclear();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
